// File: rtl/trig_record_builder.sv
// Frames TOT-triggered waveform windows into header/data/trailer words and
// queues them in a show-ahead FIFO behind a valid/ready readout stream.
module trig_record_builder #(
    parameter int PRE_GROUPS  = 2,
    parameter int POST_GROUPS = 3,
    parameter int MAX_GROUPS  = 64,
    parameter int FIFO_DEPTH  = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] in_0,
    input  logic [13:0] in_1,
    input  logic [13:0] in_2,
    input  logic [13:0] in_3,
    input  logic        tot_0,
    input  logic        tot_1,
    input  logic        tot_2,
    input  logic        tot_3,
    input  logic [17:0] bsum_in,
    input  logic        enable,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [39:0] ts_now,
    output logic [15:0] trig_dropped,
    output logic        busy
);

    localparam int DLY = PRE_GROUPS + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN,
        TRAILER
    } state_t;

    state_t      state, state_n;
    logic [7:0]  q, q_n, q_dec;
    logic [4:0]  rem, rem_n;
    logic [15:0] dcount, dcount_n;
    logic        truncated, truncated_n;
    logic        capped, capped_n;
    logic        drop_inc;

    logic        any_tot, prev_any, rise;
    logic [1:0]  lane;

    logic [59:0] dly [DLY];
    logic [59:0] dly_out;

    logic [63:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0] count, count_n, free, remain;
    logic        wr_en, pop;
    logic [63:0] wr_data;
    logic [63:0] hdr_word, data_word, trl_word;

    // Pretrigger window: data words always come from this delayed copy.
    always_ff @(posedge clk) begin
        dly[0] <= {tot_3, tot_2, tot_1, tot_0, in_3, in_2, in_1, in_0};
        for (int i = 1; i < DLY; i++) begin
            dly[i] <= dly[i-1];
        end
    end
    assign dly_out = dly[DLY-1];

    assign any_tot = tot_0 | tot_1 | tot_2 | tot_3;
    assign rise    = any_tot & ~prev_any;
    assign busy    = (state != IDLE);

    always_comb begin
        lane = 2'd0;
        if (tot_0)      lane = 2'd0;
        else if (tot_1) lane = 2'd1;
        else if (tot_2) lane = 2'd2;
        else if (tot_3) lane = 2'd3;
    end

    assign hdr_word  = {4'hA, lane, bsum_in, ts_now};
    assign data_word = {4'h5, dly_out};
    assign trl_word  = {4'hE, truncated, capped, 42'd0, dcount};

    assign free  = CW'(FIFO_DEPTH) - count;
    assign q_dec = any_tot ? 8'(POST_GROUPS) : q - 8'd1;

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default would infer a latch.
    always_comb begin
        state_n     = state;
        q_n         = q;
        rem_n       = rem;
        dcount_n    = dcount;
        truncated_n = truncated;
        capped_n    = capped;
        wr_en       = 1'b0;
        wr_data     = data_word;
        drop_inc    = 1'b0;

        case (state)
            IDLE: begin
                if (rise && enable) begin
                    if (free >= CW'(3)) begin
                        wr_en       = 1'b1;
                        wr_data     = hdr_word;
                        q_n         = 8'(POST_GROUPS);
                        dcount_n    = 16'd0;
                        truncated_n = 1'b0;
                        capped_n    = 1'b0;
                        state_n     = CAPTURE;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (free >= CW'(2)) begin
                    wr_en    = 1'b1;
                    dcount_n = dcount + 16'd1;
                    q_n      = q_dec;
                    if (dcount_n == 16'(MAX_GROUPS)) begin
                        capped_n = 1'b1;
                        state_n  = TRAILER;
                    end else if (q_dec == 8'd0) begin
                        rem_n   = 5'(DLY);
                        state_n = DRAIN;
                    end
                end else begin
                    truncated_n = 1'b1;
                    state_n     = TRAILER;
                end
            end
            DRAIN: begin
                if (free >= CW'(2)) begin
                    wr_en    = 1'b1;
                    dcount_n = dcount + 16'd1;
                    rem_n    = rem - 5'd1;
                    if (dcount_n == 16'(MAX_GROUPS)) begin
                        capped_n = 1'b1;
                        state_n  = TRAILER;
                    end else if (rem_n == 5'd0) begin
                        state_n = TRAILER;
                    end
                end else begin
                    truncated_n = 1'b1;
                    state_n     = TRAILER;
                end
            end
            TRAILER: begin
                // One slot is always held back for this word.
                wr_en   = 1'b1;
                wr_data = trl_word;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (busy && rise && enable) drop_inc = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            q            <= 8'd0;
            rem          <= 5'd0;
            dcount       <= 16'd0;
            truncated    <= 1'b0;
            capped       <= 1'b0;
            prev_any     <= 1'b0;
            ts_now       <= 40'd0;
            trig_dropped <= 16'd0;
        end else begin
            state     <= state_n;
            q         <= q_n;
            rem       <= rem_n;
            dcount    <= dcount_n;
            truncated <= truncated_n;
            capped    <= capped_n;
            prev_any  <= any_tot;
            ts_now    <= ts_now + 40'd1;
            if (drop_inc && trig_dropped != 16'hFFFF) begin
                trig_dropped <= trig_dropped + 16'd1;
            end
        end
    end

    assign pop      = out_valid & out_ready;
    assign rd_ptr_n = rd_ptr + AW'(pop);
    assign remain   = count - CW'(pop);
    assign count_n  = remain + CW'(wr_en);

    // NOTE: the storage array is not reset; validity is tracked by the
    // pointers and count, which are.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Registered head: a write into an otherwise-empty FIFO bypasses memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= 64'd0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            out_valid <= (count_n != '0);
            if (wr_en && remain == '0) out_data <= wr_data;
            else                       out_data <= mem[rd_ptr_n];
        end
    end

endmodule

// File: tb/tb_trig_record_builder.sv
// Directed bench for trig_record_builder: table of trigger scenarios plus
// hand-written sequences for FIFO truncation and mid-record reset.
module tb_trig_record_builder;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] in_0, in_1, in_2, in_3;
    logic        tot_0, tot_1, tot_2, tot_3;
    logic [17:0] bsum_in;
    logic        enable;
    logic        out_ready, out_ready_s;
    logic [63:0] out_data, out_data_s;
    logic        out_valid, out_valid_s;
    logic [39:0] ts_now, ts_now_s;
    logic [15:0] trig_dropped, trig_dropped_s;
    logic        busy, busy_s;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        string      name;
        logic [3:0] mask;
        int         t0, t1, t2;
        int         en_lo0, en_lo1;
        logic [1:0] lane;
        int         first_grp;
        int         n_data;
        bit         trunc;
        bit         capped;
        int         dropped;
    } rec_t;

    typedef struct {
        logic [63:0] w;
        int          c;
    } pop_t;

    pop_t q_main[$];
    pop_t q_small[$];
    rec_t rows[7];
    rec_t r4, r5a, r5b;

    always #5 clk = ~clk;

    trig_record_builder #(.MAX_GROUPS(16)) dut (
        .clk(clk), .reset(reset),
        .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
        .tot_0(tot_0), .tot_1(tot_1), .tot_2(tot_2), .tot_3(tot_3),
        .bsum_in(bsum_in), .enable(enable),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ts_now(ts_now), .trig_dropped(trig_dropped), .busy(busy)
    );

    trig_record_builder #(.MAX_GROUPS(16), .FIFO_DEPTH(8)) dut_small (
        .clk(clk), .reset(reset),
        .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
        .tot_0(tot_0), .tot_1(tot_1), .tot_2(tot_2), .tot_3(tot_3),
        .bsum_in(bsum_in), .enable(enable),
        .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
        .ts_now(ts_now_s), .trig_dropped(trig_dropped_s), .busy(busy_s)
    );

    function automatic logic [13:0] smp(input int g, input int k);
        return 14'((g * 4 + k) * 97 + 5);
    endfunction

    function automatic logic [17:0] bsum_of(input int g);
        return 18'(g * 37 + 1000);
    endfunction

    function automatic logic [3:0] tot_at(input rec_t r, input int g);
        return (((g >= r.t0) && (g <= r.t1)) || (g == r.t2)) ? r.mask : 4'h0;
    endfunction

    function automatic logic [63:0] data_exp(input rec_t r, input int g);
        return {4'h5, tot_at(r, g), smp(g, 3), smp(g, 2), smp(g, 1), smp(g, 0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input rec_t r, input int c);
        logic [3:0] t;
        t = tot_at(r, c);
        {tot_3, tot_2, tot_1, tot_0} = t;
        in_0    = smp(c, 0);
        in_1    = smp(c, 1);
        in_2    = smp(c, 2);
        in_3    = smp(c, 3);
        bsum_in = bsum_of(c);
        enable  = !((c >= r.en_lo0) && (c <= r.en_lo1));
    endtask

    task automatic run(input rec_t r, input int from, input int to);
        for (int c = from; c < to; c++) begin
            cyc = c;
            apply(r, c);
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {tot_3, tot_2, tot_1, tot_0} = 4'h0;
        {in_0, in_1, in_2, in_3} = '0;
        bsum_in = '0;
        enable  = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        cyc   = 0;
        q_main.delete();
        q_small.delete();
    endtask

    task automatic check_record(input rec_t r, input bit sel);
        pop_t ws[$];
        if (sel) ws = q_small;
        else     ws = q_main;
        if (r.n_data < 0) begin
            check($sformatf("%s word_count", r.name), 64'(ws.size()), 64'd0);
        end else begin
            check($sformatf("%s word_count", r.name), 64'(ws.size()), 64'(r.n_data + 2));
            if (ws.size() == r.n_data + 2) begin
                check($sformatf("%s header", r.name), ws[0].w,
                      {4'hA, r.lane, bsum_of(r.t0), 40'(r.t0)});
                if (!sel) begin
                    check($sformatf("%s header_cycle", r.name), 64'(ws[0].c), 64'(r.t0 + 1));
                    check($sformatf("%s data0_cycle", r.name), 64'(ws[1].c), 64'(r.t0 + 2));
                end
                for (int i = 0; i < r.n_data; i++) begin
                    check($sformatf("%s data%0d", r.name, i), ws[1 + i].w,
                          data_exp(r, r.first_grp + i));
                end
                check($sformatf("%s trailer", r.name), ws[r.n_data + 1].w,
                      {4'hE, r.trunc, r.capped, 42'd0, 16'(r.n_data)});
            end
        end
        if (r.dropped >= 0) begin
            check($sformatf("%s trig_dropped", r.name),
                  64'(sel ? trig_dropped_s : trig_dropped), 64'(r.dropped));
        end
        check($sformatf("%s busy_end", r.name), 64'(sel ? busy_s : busy), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready)     q_main.push_back('{w: out_data, c: cyc});
            if (out_valid_s && out_ready_s) q_small.push_back('{w: out_data_s, c: cyc});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        out_ready   = 1'b1;
        out_ready_s = 1'b1;
        enable      = 1'b1;

        rows[0] = '{name: "single", mask: 4'b0100, t0: 10, t1: 10, t2: -1, en_lo0: -1, en_lo1: -1,
                    lane: 2'd2, first_grp: 8, n_data: 6, trunc: 1'b0, capped: 1'b0, dropped: 0};
        rows[1] = '{name: "merge", mask: 4'b0001, t0: 10, t1: 10, t2: 12, en_lo0: -1, en_lo1: -1,
                    lane: 2'd0, first_grp: 8, n_data: 8, trunc: 1'b0, capped: 1'b0, dropped: -1};
        rows[2] = '{name: "split", mask: 4'b1000, t0: 10, t1: 10, t2: 14, en_lo0: -1, en_lo1: -1,
                    lane: 2'd3, first_grp: 8, n_data: 6, trunc: 1'b0, capped: 1'b0, dropped: 1};
        rows[3] = '{name: "cap", mask: 4'b0001, t0: 10, t1: 40, t2: -1, en_lo0: -1, en_lo1: -1,
                    lane: 2'd0, first_grp: 8, n_data: 16, trunc: 1'b0, capped: 1'b1, dropped: 0};
        rows[4] = '{name: "lanes", mask: 4'b0110, t0: 10, t1: 11, t2: -1, en_lo0: -1, en_lo1: -1,
                    lane: 2'd1, first_grp: 8, n_data: 7, trunc: 1'b0, capped: 1'b0, dropped: 0};
        rows[5] = '{name: "en_off", mask: 4'b0100, t0: 10, t1: 10, t2: -1, en_lo0: 5, en_lo1: 15,
                    lane: 2'd2, first_grp: 8, n_data: -1, trunc: 1'b0, capped: 1'b0, dropped: 0};
        rows[6] = '{name: "en_mid", mask: 4'b1000, t0: 10, t1: 10, t2: 14, en_lo0: 12, en_lo1: 20,
                    lane: 2'd3, first_grp: 8, n_data: 6, trunc: 1'b0, capped: 1'b0, dropped: 0};
        r4      = '{name: "trunc", mask: 4'b0001, t0: 10, t1: 12, t2: 25, en_lo0: -1, en_lo1: -1,
                    lane: 2'd0, first_grp: 8, n_data: 6, trunc: 1'b1, capped: 1'b0, dropped: 1};
        r5a     = '{name: "abort", mask: 4'b0010, t0: 10, t1: 10, t2: -1, en_lo0: -1, en_lo1: -1,
                    lane: 2'd1, first_grp: 8, n_data: 6, trunc: 1'b0, capped: 1'b0, dropped: 0};
        r5b     = '{name: "after_reset", mask: 4'b0010, t0: 5, t1: 5, t2: -1, en_lo0: -1, en_lo1: -1,
                    lane: 2'd1, first_grp: 3, n_data: 6, trunc: 1'b0, capped: 1'b0, dropped: 0};

        do_reset();
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset ts_now", 64'(ts_now), 64'd0);
        check("reset trig_dropped", 64'(trig_dropped), 64'd0);
        check("reset small out_valid", 64'(out_valid_s), 64'd0);

        foreach (rows[i]) begin
            do_reset();
            run(rows[i], 0, 64);
            check($sformatf("%s ts_now", rows[i].name), 64'(ts_now), 64'd64);
            check_record(rows[i], 1'b0);
        end

        // Stalled consumer on the 8-deep instance: truncation then a drop.
        out_ready_s = 1'b0;
        do_reset();
        run(r4, 0, 40);
        check("trunc held out_valid", 64'(out_valid_s), 64'd1);
        check("trunc held dropped", 64'(trig_dropped_s), 64'd1);
        out_ready_s = 1'b1;
        run(r4, 40, 52);
        check_record(r4, 1'b1);
        check("trunc drained out_valid", 64'(out_valid_s), 64'd0);

        // Reset two cycles into CAPTURE, then a clean record.
        do_reset();
        run(r5a, 0, 13);
        check("abort busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort ts_now", 64'(ts_now), 64'd0);
        check("abort trig_dropped", 64'(trig_dropped), 64'd0);
        do_reset();
        run(r5b, 0, 40);
        check_record(r5b, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trig_record_builder.md
Name: trig_record_builder

Overview:
- Downstream consumer of the FIR trigger stage.
- Takes the four aligned raw samples, the four TOT bits and the baseline sum per clock (one 4-sample group per cycle).
- Frames triggered waveform windows (pretrigger + TOT span + posttrigger) into header/data/trailer 64-bit words.
- Buffers the words in an internal show-ahead FIFO behind a valid/ready output stream for readout.

Parameters:
PRE_GROUPS, 2, groups captured before trigger group (1..15)
POST_GROUPS, 3, groups captured after last TOT group of record (1..255)
MAX_GROUPS, 64, maximum data words per record (PRE_GROUPS+1..65535)
FIFO_DEPTH, 256, output FIFO depth in 64-bit words (power of 2, >=8)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_0..in_3  in  14 each  aligned raw samples (offset binary), in_0 earliest
tot_0..tot_3  in  1 each  time-over-threshold bits aligned with in_x
bsum_in  in  18  baseline sum aligned with samples
enable  in  1  1 = new triggers accepted
out_data  out  64  FIFO head word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head word this cycle
ts_now  out  40  free-running group timestamp
trig_dropped  out  16  saturating count of lost triggers
busy  out  1  record in progress

Behaviour:
- Reset: out_valid=0, FIFO empty, ts_now=0, trig_dropped=0, busy=0, FSM=IDLE. Reset mid-record discards the partial record and all FIFO contents.
- ts_now increments by 1 every cycle and wraps at 2^40.
- any_tot = OR of tot_0..tot_3. A rising edge is any_tot=1 with the previous cycle's any_tot=0.
- Sample path: {in_3,in_2,in_1,in_0} and tot bits pass through a delay of PRE_GROUPS+1 cycles. Data words are always taken from the delayed path.
- Word formats:
  - Header: [63:60]=4'hA, [59:58]=lowest asserted tot lane in trigger group, [57:40]=bsum_in at trigger, [39:0]=ts_now at trigger.
  - Data: [63:60]=4'h5, [59:56]={tot_3..tot_0} delayed, [55:0] delayed samples.
  - Trailer: [63:60]=4'hE, [59]=truncated, [58]=capped, [57:16]=0, [15:0]=data word count.
- FSM states: IDLE, CAPTURE, DRAIN, TRAILER.
- IDLE:
  - On a rising edge with enable=1 and FIFO free >=3: write header, set post counter q=POST_GROUPS, go to CAPTURE, busy=1.
  - On a rising edge with enable=1 and free <3: trig_dropped++ (saturating at 16'hFFFF), stay in IDLE.
- CAPTURE (one data word per cycle):
  - If any_tot then q=POST_GROUPS, else q=q-1.
  - When q reaches 0, go to DRAIN with PRE_GROUPS+1 words remaining.
  - Net result: data words cover groups T-PRE_GROUPS .. L+POST_GROUPS, where T is the trigger group and L is the last TOT group with no TOT-free gap >= POST_GROUPS before it.
- DRAIN: keep writing data words until the remaining count is exhausted, then go to TRAILER.
- Cap: when data count reaches MAX_GROUPS in CAPTURE or DRAIN, set capped=1 and go to TRAILER immediately.
- Truncation: a data word is written only if FIFO free >=2, so one slot stays reserved for the trailer. Otherwise set truncated=1, drop the word and go to TRAILER.
- TRAILER: write trailer (always fits), go to IDLE, busy=0. Trailer count = data words actually written.
- Rising edges seen while busy=1 with enable=1 increment trig_dropped. A TOT still high on return to IDLE does not trigger, because only a rising edge does.
- enable falling mid-record does not abort the record.
- FIFO:
  - Write and read in the same cycle are both allowed.
  - out_data/out_valid are registered.
  - A word written in cycle c is visible at c+1 if the FIFO was empty.
  - Pop happens when out_valid && out_ready.
- Latency: trigger group at cycle t gives the header at the output at t+1 and the first data word at t+2 (empty FIFO, out_ready=1).

Test Plan:
Defaults except MAX_GROUPS=16, out_ready=1, enable=1.
1. tot_2=1 only at ts 10 -> header lane=2, ts=10; 6 data words for groups 8..13 (tot nibble 4'h4 on word 3); trailer count=6, flags 0.
2. TOT at ts 10 and 12 -> single record, groups 8..15, count=8. TOT at ts 10 and 14 -> record groups 8..13 and trig_dropped=1.
3. tot_0 held high ts 10..40 -> trailer capped=1, count=16; no second record until TOT falls and rises again.
4. FIFO_DEPTH=8, out_ready=0, TOT ts 10..12 -> header + 6 data words + trailer (truncated=1, count=6). Next TOT while FIFO full -> trig_dropped=1.
5. reset asserted two cycles into CAPTURE -> next cycle out_valid=0, busy=0, ts_now=0, trig_dropped=0. Rising TOT after release -> clean record.
6. enable=0 with a TOT pulse -> no words and trig_dropped unchanged. enable dropped mid-record -> record completes normally.
